// File: rtl/pi_txn_frontend.sv
// Pi GPIO register front end: decodes strobed register writes into single 68k bus
// requests, tracks the response and exposes read data, status flags and CTRL.
module pi_txn_frontend #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 4095,
    parameter int TIMEOUT_W      = 12
) (
    input  logic        PI_CLK,
    input  logic        SYS_RESET_n,
    input  logic [1:0]  PI_A,
    input  logic        PI_RD,
    input  logic        PI_WR,
    input  logic [15:0] PI_D_IN,
    output logic [15:0] PI_D_OUT,
    output logic        PI_D_OE,
    output logic        REQ_VALID,
    input  logic        REQ_READY,
    output logic [23:0] REQ_ADDR,
    output logic        REQ_RW,
    output logic        REQ_UDS_n,
    output logic        REQ_LDS_n,
    output logic [2:0]  REQ_FC,
    output logic [15:0] REQ_WDATA,
    input  logic        RSP_VALID,
    input  logic        RSP_BERR,
    input  logic [15:0] RSP_RDATA,
    input  logic [2:0]  IPL,
    output logic        TXN_IN_PROGRESS,
    output logic [15:0] CTRL
);

    localparam bit                 TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [TIMEOUT_W-1:0] TO_LOAD =
        TIMEOUT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PEND, WAIT} state_t;
    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] rd_sync_q, wr_sync_q;
    logic                   rd_evt, wr_evt;

    logic [15:0]          wdata_q, wdata_d, addr_lo_q, addr_lo_d, rdata_q, rdata_d, ctrl_q, ctrl_d;
    logic                 txn_q, txn_d, berr_q, berr_d, ovr_q, ovr_d, aerr_q, aerr_d, tmo_q, tmo_d;
    logic                 req_valid_q, req_valid_d, req_rw_q, req_rw_d;
    logic                 req_uds_q, req_uds_d, req_lds_q, req_lds_d;
    logic [23:0]          req_addr_q, req_addr_d;
    logic [2:0]           req_fc_q, req_fc_d;
    logic [15:0]          req_wdata_q, req_wdata_d;
    logic [TIMEOUT_W-1:0] to_cnt_q, to_cnt_d;

    logic launch_wr, word_odd, launch, accept, rsp_done, to_hit, stat_clr;
    logic unused_d_in;

    assign unused_d_in = ^PI_D_IN[12:10];

    // Edge = 0->1 between the last two synchroniser stages
    always_ff @(posedge PI_CLK) begin
        if (!SYS_RESET_n) begin
            rd_sync_q <= '0;
            wr_sync_q <= '0;
        end else begin
            rd_sync_q <= {rd_sync_q[SYNC_STAGES-2:0], PI_RD};
            wr_sync_q <= {wr_sync_q[SYNC_STAGES-2:0], PI_WR};
        end
    end

    assign rd_evt = rd_sync_q[SYNC_STAGES-2] & ~rd_sync_q[SYNC_STAGES-1];
    assign wr_evt = wr_sync_q[SYNC_STAGES-2] & ~wr_sync_q[SYNC_STAGES-1];

    assign launch_wr = wr_evt && (PI_A == 2'd2);
    assign word_odd  = !PI_D_IN[8] && addr_lo_q[0];
    assign launch    = launch_wr && (state_q == IDLE) && !word_odd;
    assign accept    = (state_q == PEND) && req_valid_q && REQ_READY;
    assign rsp_done  = (state_q == WAIT) && RSP_VALID;
    assign to_hit    = TO_EN && (state_q == WAIT) && !RSP_VALID && (to_cnt_q == '0);
    assign stat_clr  = rd_evt && (PI_A == 2'd3);

    always_ff @(posedge PI_CLK) begin
        if (!SYS_RESET_n) state_q <= IDLE;
        else              state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (launch) state_d = PEND;
            PEND:    if (accept) state_d = WAIT;
            WAIT:    if (rsp_done || to_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wdata_d     = wdata_q;
        addr_lo_d   = addr_lo_q;
        rdata_d     = rdata_q;
        ctrl_d      = ctrl_q;
        txn_d       = txn_q;
        req_valid_d = req_valid_q;
        req_addr_d  = req_addr_q;
        req_rw_d    = req_rw_q;
        req_uds_d   = req_uds_q;
        req_lds_d   = req_lds_q;
        req_fc_d    = req_fc_q;
        req_wdata_d = req_wdata_q;
        to_cnt_d    = to_cnt_q;
        // Read-clear first so a same-cycle set below wins
        berr_d      = stat_clr ? 1'b0 : berr_q;
        ovr_d       = stat_clr ? 1'b0 : ovr_q;
        aerr_d      = stat_clr ? 1'b0 : aerr_q;
        tmo_d       = stat_clr ? 1'b0 : tmo_q;

        if (wr_evt && PI_A == 2'd0) wdata_d = PI_D_IN;
        if (wr_evt && PI_A == 2'd3) ctrl_d  = PI_D_IN;

        if (launch_wr) begin
            if (state_q != IDLE) begin
                ovr_d = 1'b1;
            end else if (word_odd) begin
                aerr_d = 1'b1;
                txn_d  = 1'b0;
            end else begin
                req_valid_d = 1'b1;
                req_addr_d  = {PI_D_IN[7:0], addr_lo_q};
                req_rw_d    = PI_D_IN[9];
                req_uds_d   = PI_D_IN[8] ? addr_lo_q[0] : 1'b0;
                req_lds_d   = PI_D_IN[8] ? !addr_lo_q[0] : 1'b0;
                req_fc_d    = PI_D_IN[15:13];
                req_wdata_d = wdata_q;
            end
        end

        if (accept) begin
            req_valid_d = 1'b0;
            to_cnt_d    = TO_LOAD;
        end else if (state_q == WAIT && !RSP_VALID && to_cnt_q != '0) begin
            to_cnt_d = to_cnt_q - 1'b1;
        end

        if (rsp_done) begin
            if (req_rw_q) rdata_d = RSP_RDATA;
            berr_d = berr_d | RSP_BERR;
            txn_d  = 1'b0;
        end
        if (to_hit) begin
            berr_d = 1'b1;
            tmo_d  = 1'b1;
            txn_d  = 1'b0;
        end

        if (wr_evt && PI_A == 2'd1) begin
            addr_lo_d = PI_D_IN;
            txn_d     = 1'b1;
        end
    end

    always_ff @(posedge PI_CLK) begin
        if (!SYS_RESET_n) begin
            wdata_q     <= '0;
            addr_lo_q   <= '0;
            rdata_q     <= '0;
            ctrl_q      <= '0;
            txn_q       <= 1'b0;
            berr_q      <= 1'b0;
            ovr_q       <= 1'b0;
            aerr_q      <= 1'b0;
            tmo_q       <= 1'b0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            req_rw_q    <= 1'b1;
            req_uds_q   <= 1'b1;
            req_lds_q   <= 1'b1;
            req_fc_q    <= 3'b111;
            req_wdata_q <= '0;
            to_cnt_q    <= '0;
        end else begin
            wdata_q     <= wdata_d;
            addr_lo_q   <= addr_lo_d;
            rdata_q     <= rdata_d;
            ctrl_q      <= ctrl_d;
            txn_q       <= txn_d;
            berr_q      <= berr_d;
            ovr_q       <= ovr_d;
            aerr_q      <= aerr_d;
            tmo_q       <= tmo_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            req_rw_q    <= req_rw_d;
            req_uds_q   <= req_uds_d;
            req_lds_q   <= req_lds_d;
            req_fc_q    <= req_fc_d;
            req_wdata_q <= req_wdata_d;
            to_cnt_q    <= to_cnt_d;
        end
    end

    assign REQ_VALID       = req_valid_q;
    assign REQ_ADDR        = req_addr_q;
    assign REQ_RW          = req_rw_q;
    assign REQ_UDS_n       = req_uds_q;
    assign REQ_LDS_n       = req_lds_q;
    assign REQ_FC          = req_fc_q;
    assign REQ_WDATA       = req_wdata_q;
    assign TXN_IN_PROGRESS = txn_q;
    assign CTRL            = ctrl_q;

    assign PI_D_OE = PI_RD && (PI_A == 2'd0 || PI_A == 2'd3);

    always_comb begin
        PI_D_OUT = '0;
        if (PI_D_OE) begin
            if (PI_A == 2'd0) PI_D_OUT = rdata_q;
            else PI_D_OUT = {IPL, 8'd0, tmo_q, aerr_q, ovr_q, (state_q != IDLE), berr_q};
        end
    end

endmodule
